// File: rtl/decode_stage_hs_pkg.sv
// Shared decode types: ALU operations, instruction formats, RV32I opcodes.
// The optional DECODE_WB_BYPASS_EN build switch is consumed by decode_stage_hs.
package decode_stage_hs_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        TYPE_R = 3'd0,
        TYPE_I = 3'd1,
        TYPE_S = 3'd2,
        TYPE_B = 3'd3,
        TYPE_U = 3'd4,
        TYPE_J = 3'd5
    } instr_type_e;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    // sub/sra come from funct7[5]; the caller decides whether sub may apply.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3,
                                                input logic sub,
                                                input logic sra);
        case (funct3)
            3'd0:    return sub ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return sra ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_hs_imm_gen.sv
// Immediate generator: I/S/B/U/J immediates sign-extended to XLEN (R yields 0).
module decode_stage_hs_imm_gen
    import decode_stage_hs_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  instr_type_e     itype,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (itype)
            TYPE_I:  imm32 = {{20{instr[31]}}, instr[31:20]};
            TYPE_S:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            TYPE_B:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            TYPE_U:  imm32 = {instr[31:12], 12'b0};
            TYPE_J:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage_hs.sv
// RV32I/RV32E decode stage with valid/ready handshakes, load-use scoreboard and flush.
// Define DECODE_WB_BYPASS_EN to forward writeback data and release hazards in the writeback cycle.
module decode_stage_hs
    import decode_stage_hs_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [31:0]      in_instr,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             ex_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_rs1_data,
    output logic [XLEN-1:0]  out_rs2_data,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_funct3,
    output alu_op_e          out_alu_op,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic             out_reg_write,
    output logic             out_use_imm,
    output logic             out_use_pc,
    output logic             out_is_jump,
    output logic             out_is_branch,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int AW = $clog2(NUM_REGS);
    localparam logic [5:0] NREGS6 = 6'(NUM_REGS);

    function automatic logic in_range(input logic [4:0] idx);
        return {1'b0, idx} < NREGS6;
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1, rs2, rd;
    instr_type_e     itype;
    alu_op_e         alu_op;
    logic            known, dec_mem_read, dec_mem_write, dec_reg_write;
    logic            dec_use_pc, dec_is_jump, dec_is_branch;
    logic            use_rs1, use_rs2, use_rd, range_bad, dec_illegal;
    logic [XLEN-1:0] dec_imm, rs1_data, rs2_data;

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending, pend_vis, set_mask, clr_mask;
    logic                rs1_busy, rs2_busy, hazard, fire_in, fire_out;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    always_comb begin
        itype         = TYPE_R;
        alu_op        = ALU_ADD;
        known         = 1'b1;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_reg_write = 1'b0;
        dec_use_pc    = 1'b0;
        dec_is_jump   = 1'b0;
        dec_is_branch = 1'b0;
        case (opcode)
            OPC_OP: begin
                alu_op        = alu_from_funct3(funct3, funct7[5], funct7[5]);
                dec_reg_write = 1'b1;
                known = (funct7 == 7'h00) ||
                        (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
            end
            OPC_OP_IMM: begin
                // funct7[5] is immediate data for ADDI, so only shifts look at it
                itype         = TYPE_I;
                alu_op        = alu_from_funct3(funct3, 1'b0, funct7[5]);
                dec_reg_write = 1'b1;
                if (funct3 == 3'd1)
                    known = (funct7 == 7'h00);
                else if (funct3 == 3'd5)
                    known = (funct7 == 7'h00) || (funct7 == 7'h20);
            end
            OPC_LOAD: begin
                itype         = TYPE_I;
                dec_mem_read  = 1'b1;
                dec_reg_write = 1'b1;
                known = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
            end
            OPC_STORE: begin
                itype         = TYPE_S;
                dec_mem_write = 1'b1;
                known = !funct3[2] && (funct3 != 3'd3);
            end
            OPC_BRANCH: begin
                itype         = TYPE_B;
                dec_use_pc    = 1'b1;
                dec_is_branch = 1'b1;
                known = (funct3 != 3'd2) && (funct3 != 3'd3);
            end
            OPC_JAL: begin
                itype         = TYPE_J;
                dec_reg_write = 1'b1;
                dec_use_pc    = 1'b1;
                dec_is_jump   = 1'b1;
            end
            OPC_JALR: begin
                itype         = TYPE_I;
                dec_reg_write = 1'b1;
                dec_is_jump   = 1'b1;
                known = (funct3 == 3'd0);
            end
            OPC_LUI: begin
                itype         = TYPE_U;
                alu_op        = ALU_PASS_B;
                dec_reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                itype         = TYPE_U;
                dec_reg_write = 1'b1;
                dec_use_pc    = 1'b1;
            end
            OPC_SYSTEM: begin
                itype = TYPE_I;
                known = (funct3 == 3'd0);
            end
            default: known = 1'b0;
        endcase
    end

    assign use_rs1 = known && (itype == TYPE_R || itype == TYPE_I || itype == TYPE_S || itype == TYPE_B);
    assign use_rs2 = known && (itype == TYPE_R || itype == TYPE_S || itype == TYPE_B);
    assign use_rd  = known && (itype == TYPE_R || itype == TYPE_I || itype == TYPE_U || itype == TYPE_J);

    assign range_bad   = (use_rs1 && !in_range(rs1)) || (use_rs2 && !in_range(rs2)) ||
                         (use_rd && !in_range(rd));
    assign dec_illegal = !known || range_bad;

    decode_stage_hs_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr[31:7]),
        .itype (itype),
        .imm   (dec_imm)
    );

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1 != '0 && in_range(rs1))
            rs1_data = regs[rs1[AW-1:0]];
        if (rs2 != '0 && in_range(rs2))
            rs2_data = regs[rs2[AW-1:0]];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && wb_addr == rs1 && rs1 != '0)
            rs1_data = wb_data;
        if (wb_en && wb_addr == rs2 && rs2 != '0)
            rs2_data = wb_data;
`endif
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (fire_out && out_mem_read && out_rd != '0 && in_range(out_rd))
            set_mask[out_rd[AW-1:0]] = 1'b1;
        if (wb_en && in_range(wb_addr))
            clr_mask[wb_addr[AW-1:0]] = 1'b1;
    end

`ifdef DECODE_WB_BYPASS_EN
    assign pend_vis = pending & ~clr_mask;
`else
    assign pend_vis = pending;
`endif

    // A load still sitting in the output register has not reached the scoreboard yet.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (use_rs1 && rs1 != '0 && in_range(rs1))
            rs1_busy = pend_vis[rs1[AW-1:0]] || (out_valid && out_mem_read && out_rd == rs1);
        if (use_rs2 && rs2 != '0 && in_range(rs2))
            rs2_busy = pend_vis[rs2[AW-1:0]] || (out_valid && out_mem_read && out_rd == rs2);
    end

    assign hazard   = rs1_busy || rs2_busy;
    assign in_ready = !flush && !hazard && (!out_valid || ex_ready);
    assign fire_in  = in_valid && in_ready;
    assign fire_out = out_valid && ex_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wb_en && wb_addr != '0 && in_range(wb_addr)) begin
            regs[wb_addr[AW-1:0]] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pending <= '0;
        else
            pending <= (pending & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (in_valid && hazard && !flush && stall_cycles != '1)
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_rs1_data  <= '0;
            out_rs2_data  <= '0;
            out_imm       <= '0;
            out_rs1       <= '0;
            out_rs2       <= '0;
            out_rd        <= '0;
            out_funct3    <= '0;
            out_alu_op    <= ALU_ADD;
            out_mem_read  <= 1'b0;
            out_mem_write <= 1'b0;
            out_reg_write <= 1'b0;
            out_use_imm   <= 1'b0;
            out_use_pc    <= 1'b0;
            out_is_jump   <= 1'b0;
            out_is_branch <= 1'b0;
            out_illegal   <= 1'b0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (fire_in)
                out_valid <= 1'b1;
            else if (fire_out)
                out_valid <= 1'b0;

            if (fire_in) begin
                out_pc        <= in_pc;
                out_rs1_data  <= rs1_data;
                out_rs2_data  <= rs2_data;
                out_imm       <= dec_imm;
                out_rs1       <= rs1;
                out_rs2       <= rs2;
                out_rd        <= rd;
                out_funct3    <= funct3;
                out_alu_op    <= alu_op;
                out_mem_read  <= dec_mem_read && !dec_illegal;
                out_mem_write <= dec_mem_write && !dec_illegal;
                out_reg_write <= dec_reg_write && !dec_illegal;
                out_use_imm   <= (itype != TYPE_R);
                out_use_pc    <= dec_use_pc;
                out_is_jump   <= dec_is_jump;
                out_is_branch <= dec_is_branch;
                out_illegal   <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed bench for decode_stage_hs: decode table, load-use interlock, hold, flush, reset, RV32E.
module tb_decode_stage_hs;
    import decode_stage_hs_pkg::*;

    localparam int XLEN = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, wb_en, flush, ex_ready;
    logic [XLEN-1:0]  in_pc, wb_data;
    logic [31:0]      in_instr;
    logic [4:0]       wb_addr;

    logic             in_ready, out_valid;
    logic [XLEN-1:0]  out_pc, out_rs1_data, out_rs2_data, out_imm;
    logic [4:0]       out_rs1, out_rs2, out_rd;
    logic [2:0]       out_funct3;
    alu_op_e          out_alu_op;
    logic             out_mem_read, out_mem_write, out_reg_write, out_use_imm;
    logic             out_use_pc, out_is_jump, out_is_branch, out_illegal;
    logic [31:0]      stall_cycles;

    logic             e_in_ready, e_out_valid;
    logic [XLEN-1:0]  e_out_pc, e_out_rs1_data, e_out_rs2_data, e_out_imm;
    logic [4:0]       e_out_rs1, e_out_rs2, e_out_rd;
    logic [2:0]       e_out_funct3;
    alu_op_e          e_out_alu_op;
    logic             e_out_mem_read, e_out_mem_write, e_out_reg_write, e_out_use_imm;
    logic             e_out_use_pc, e_out_is_jump, e_out_is_branch, e_out_illegal;
    logic [31:0]      e_stall_cycles;

    logic [7:0]       flags;
    assign flags = {out_mem_read, out_mem_write, out_reg_write, out_use_imm,
                    out_use_pc, out_is_jump, out_is_branch, out_illegal};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_stage_hs u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .ex_ready(ex_ready),
        .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_funct3(out_funct3), .out_alu_op(out_alu_op), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_reg_write(out_reg_write),
        .out_use_imm(out_use_imm), .out_use_pc(out_use_pc), .out_is_jump(out_is_jump),
        .out_is_branch(out_is_branch), .out_illegal(out_illegal),
        .stall_cycles(stall_cycles)
    );

    decode_stage_hs #(.NUM_REGS(16)) u_dut_e (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(e_in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush), .out_valid(e_out_valid), .ex_ready(ex_ready),
        .out_pc(e_out_pc), .out_rs1_data(e_out_rs1_data), .out_rs2_data(e_out_rs2_data),
        .out_imm(e_out_imm), .out_rs1(e_out_rs1), .out_rs2(e_out_rs2), .out_rd(e_out_rd),
        .out_funct3(e_out_funct3), .out_alu_op(e_out_alu_op), .out_mem_read(e_out_mem_read),
        .out_mem_write(e_out_mem_write), .out_reg_write(e_out_reg_write),
        .out_use_imm(e_out_use_imm), .out_use_pc(e_out_use_pc), .out_is_jump(e_out_is_jump),
        .out_is_branch(e_out_is_branch), .out_illegal(e_out_illegal),
        .stall_cycles(e_stall_cycles)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        ex_ready = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] imm;
        alu_op_e     alu;
        logic [7:0]  flg;   // mem_read mem_write reg_write use_imm use_pc is_jump is_branch illegal
    } vec_t;

    vec_t vecs[$];
    int   exp_stall;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{"addi", 32'h00500093, 32'h00000005, ALU_ADD,    8'b00110000});
        vecs.push_back('{"sub",  32'h402082B3, 32'h00000000, ALU_SUB,    8'b00100000});
        vecs.push_back('{"srai", 32'h4030D313, 32'h00000403, ALU_SRA,    8'b00110000});
        vecs.push_back('{"addim",32'hFFF08413, 32'hFFFFFFFF, ALU_ADD,    8'b00110000});
        vecs.push_back('{"sw",   32'hFE20AE23, 32'hFFFFFFFC, ALU_ADD,    8'b01010000});
        vecs.push_back('{"lui",  32'h123453B7, 32'h12345000, ALU_PASS_B, 8'b00110000});
        vecs.push_back('{"auipc",32'h00001497, 32'h00001000, ALU_ADD,    8'b00111000});
        vecs.push_back('{"beq",  32'hFE208CE3, 32'hFFFFFFF8, ALU_ADD,    8'b00011010});
        vecs.push_back('{"jal",  32'h001000EF, 32'h00000800, ALU_ADD,    8'b00111100});
        vecs.push_back('{"jalr", 32'h000100E7, 32'h00000000, ALU_ADD,    8'b00110100});
        vecs.push_back('{"sltu", 32'h0020B1B3, 32'h00000000, ALU_SLTU,   8'b00100000});
        vecs.push_back('{"op7f", 32'h0000007F, 32'h00000000, ALU_ADD,    8'b00000001});
        vecs.push_back('{"mul",  32'h022081B3, 32'h00000000, ALU_ADD,    8'b00000001});

        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; ex_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_stall", stall_cycles, 0);
        check("rst_imm", out_imm, 0);
        check("rst_pc", out_pc, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b0;
        step();

        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd100;
        step();
        wb_addr = 5'd2; wb_data = 32'd7;
        step();
        wb_en = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].instr, 32'h1000 + 32'(i * 4));
            check({vecs[i].name, "_valid"}, out_valid, 1);
            check({vecs[i].name, "_pc"}, out_pc, 32'h1000 + 32'(i * 4));
            check({vecs[i].name, "_imm"}, out_imm, vecs[i].imm);
            check({vecs[i].name, "_alu"}, out_alu_op, vecs[i].alu);
            check({vecs[i].name, "_flags"}, flags, vecs[i].flg);
        end

        issue(32'h001122B3, 32'h1100);               // SLT x5,x2,x1
        check("slt_alu", out_alu_op, ALU_SLT);
        check("slt_rs1_data", out_rs1_data, 32'd7);
        check("slt_rs2_data", out_rs2_data, 32'd100);
        step();

        // LW x3,0(x1) then ADD x4,x3,x2
        issue(32'h0000A183, 32'h2000);
        in_valid = 1'b1; in_instr = 32'h00218233; in_pc = 32'h2004;
        #1;
        check("lu_ready_t0", in_ready, 0);
        step();
        check("lu_ready_t1", in_ready, 0);
        check("lu_load_left", out_valid, 0);
        step();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
        #1;
`ifdef DECODE_WB_BYPASS_EN
        check("lu_ready_wb", in_ready, 1);
        step();
        wb_en = 1'b0; in_valid = 1'b0;
        exp_stall = 2;
`else
        check("lu_ready_wb", in_ready, 0);
        step();
        wb_en = 1'b0;
        #1;
        check("lu_ready_after", in_ready, 1);
        step();
        in_valid = 1'b0;
        exp_stall = 3;
`endif
        check("lu_out_valid", out_valid, 1);
        check("lu_out_rd", out_rd, 4);
        check("lu_rs1_data", out_rs1_data, 32'h55);
        check("lu_rs2_data", out_rs2_data, 32'd7);
        check("lu_stall_cnt", stall_cycles, exp_stall);

        step();
        issue(32'h00108513, 32'h3000);               // ADDI x10,x1,1
        ex_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00210593; in_pc = 32'h3004;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("hold_in_ready", in_ready, 0);
            check("hold_valid", out_valid, 1);
            check("hold_pc", out_pc, 32'h3000);
            check("hold_imm", out_imm, 32'd1);
            step();
        end
        ex_ready = 1'b1;
        #1;
        check("hold_release_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("hold_next_pc", out_pc, 32'h3004);
        check("hold_next_imm", out_imm, 32'd2);

        step();
        issue(32'h0000A283, 32'h4000);               // LW x5,0(x1)
        step();
        issue(32'h00300613, 32'h4008);               // ADDI x12,x0,3
        ex_ready = 1'b0; flush = 1'b1;
        in_valid = 1'b1; in_instr = 32'h00400693; in_pc = 32'h400C;
        #1;
        check("flush_in_ready", in_ready, 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        in_instr = 32'h00028733; in_valid = 1'b1; ex_ready = 1'b1;   // ADD x14,x5,x0
        #1;
        check("flush_pending_kept", in_ready, 0);
        check("flush_stall_cnt", stall_cycles, exp_stall);

        in_instr = 32'h00900793; in_pc = 32'h4010; ex_ready = 1'b0;  // ADDI x15,x0,9
        step();
        in_instr = 32'h00028733; in_pc = 32'h4014;
        step();
        step();
        check("pre_rst_stall", stall_cycles, exp_stall + 2);
        check("pre_rst_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_stall", stall_cycles, 0);
        check("async_rst_pc", out_pc, 0);
        check("async_rst_scoreboard", in_ready, 1);
        step();
        reset = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
        step();

        issue(32'h002088B3, 32'h5000);               // ADD x17,x1,x2
        check("e_x17_valid", e_out_valid, 1);
        check("e_x17_illegal", e_out_illegal, 1);
        check("e_x17_reg_write", e_out_reg_write, 0);
        check("i_x17_illegal", out_illegal, 0);
        check("i_x17_reg_write", out_reg_write, 1);
        issue(32'h0000007F, 32'h5004);
        check("e_op7f_illegal", e_out_illegal, 1);
        issue(32'h002081B3, 32'h5008);               // ADD x3,x1,x2
        check("e_x3_illegal", e_out_illegal, 0);
        check("e_x3_reg_write", e_out_reg_write, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
